// File: rtl/sha3_pkg.sv
// sha3_pkg: shared constants and state type for the SHA3 pad sequencer
package sha3_pkg;
   localparam int         RATE_WORDS_256 = 17;
   localparam logic [7:0] PAD_DS_SHA3    = 8'h06;
   localparam logic [7:0] PAD_DS_SHAKE   = 8'h1F;
   localparam logic [7:0] PAD_END        = 8'h80;
   typedef enum logic [1:0] {ACCEPT, PAD, FULL} pad_state_t;
endpackage

// File: rtl/sha3_pad_word.sv
// sha3_pad_word: truncates a word to its valid bytes, appends the domain byte and the end-of-block marker
module sha3_pad_word
   import sha3_pkg::*;
(
   input  logic [63:0] i_word,
   input  logic [3:0]  i_byte_num,
   input  logic [7:0]  i_ds_byte,
   input  logic        i_final_slot,
   input  logic        i_is_pad_only,
   output logic [63:0] o_word
);
   logic [3:0]  w_n;
   logic [63:0] w_keep;
   logic [63:0] w_pad;
   logic [63:0] w_end;
   // byte counts above 8 mean a full word with no padding in it
   assign w_n    = (i_byte_num > 4'd8) ? 4'd8 : i_byte_num;
   assign w_keep = i_word & ~(64'hFFFF_FFFF_FFFF_FFFF >> {w_n, 3'b000});
   assign w_pad  = (w_n == 4'd8) ? 64'd0 : ({56'd0, i_ds_byte} << {4'd7 - w_n, 3'b000});
   // a full data word in the last slot is not the end of padding; a pure pad word always is
   assign w_end  = (i_final_slot & ((w_n != 4'd8) | i_is_pad_only)) ? {56'd0, PAD_END} : 64'd0;
   assign o_word = w_keep | w_pad | w_end;
endmodule

// File: rtl/sha3_pad_sequencer.sv
// sha3_pad_sequencer: collects 64-bit words into SHA3 rate blocks, pads the message tail (optional SHAKE domain via SHA3_PAD_SHAKE_EN)
module sha3_pad_sequencer
   import sha3_pkg::*;
#(
   parameter int RATE_WORDS = RATE_WORDS_256,
   parameter int WORD_W     = 64
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WORD_W-1:0]            in,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         is_last,
   input  logic [3:0]                   byte_num,
`ifdef SHA3_PAD_SHAKE_EN
   input  logic                         shake_mode,
`endif
   output logic [RATE_WORDS*WORD_W-1:0] out_block,
   output logic                         out_valid,
   input  logic                         out_ack,
   output logic                         msg_done
);
   localparam int            CW        = $clog2(RATE_WORDS + 1);
   localparam logic [CW-1:0] LAST_SLOT = CW'(RATE_WORDS - 1);
   pad_state_t                   r_state;
   logic [CW-1:0]                r_cnt;
   logic [RATE_WORDS*WORD_W-1:0] r_buf;
   logic                         r_pad_pending;
   logic                         r_final;
   logic                         r_out_valid;
   logic                         r_msg_done;
   logic [7:0]                   r_ds;
   logic [7:0]                   w_ds_live;
   logic [7:0]                   w_ds;
   logic                         w_accept;
   logic                         w_xfer;
   logic                         w_slot_last;
   logic                         w_last_short;
   logic [3:0]                   w_byte_num;
   logic [WORD_W-1:0]            w_word;
   logic [WORD_W-1:0]            w_padded;
   logic [RATE_WORDS*WORD_W-1:0] w_shift;
`ifdef SHA3_PAD_SHAKE_EN
   assign w_ds_live = shake_mode ? PAD_DS_SHAKE : PAD_DS_SHA3;
`else
   assign w_ds_live = PAD_DS_SHA3;
`endif
   assign w_accept     = (r_state == ACCEPT);
   assign in_ready     = ~reset & w_accept;
   assign w_xfer       = in_valid & in_ready;
   assign w_slot_last  = (r_cnt == LAST_SLOT);
   assign w_last_short = is_last & (byte_num < 4'd8);
   // pad-fill words: the domain byte leads the first one only when the last data word was full
   assign w_word       = w_accept ? in : '0;
   assign w_byte_num   = w_accept ? (is_last ? byte_num : 4'd8) : (r_pad_pending ? 4'd0 : 4'd8);
   assign w_ds         = w_accept ? w_ds_live : r_ds;
   assign w_shift      = {r_buf[(RATE_WORDS-1)*WORD_W-1:0], w_padded};
   sha3_pad_word u_pad (
      .i_word        (w_word),
      .i_byte_num    (w_byte_num),
      .i_ds_byte     (w_ds),
      .i_final_slot  (w_slot_last),
      .i_is_pad_only (~w_accept),
      .o_word        (w_padded)
   );
   // block sequencer: accept words, fill padding, hold the full block until acked
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ACCEPT;
         r_cnt         <= '0;
         r_buf         <= '0;
         r_pad_pending <= 1'b0;
         r_final       <= 1'b0;
         r_out_valid   <= 1'b0;
         r_msg_done    <= 1'b0;
         r_ds          <= PAD_DS_SHA3;
      end else begin
         r_msg_done <= 1'b0;
         case (r_state)
            ACCEPT: if (w_xfer) begin
               r_buf <= w_shift;
               r_cnt <= r_cnt + 1'b1;
               if (is_last) begin
                  r_ds          <= w_ds_live;
                  r_pad_pending <= ~w_last_short;
               end
               if (w_slot_last) begin
                  r_state     <= FULL;
                  r_out_valid <= 1'b1;
                  r_final     <= w_last_short;
               end else if (is_last) begin
                  r_state <= PAD;
               end
            end
            PAD: begin
               r_buf         <= w_shift;
               r_cnt         <= r_cnt + 1'b1;
               r_pad_pending <= 1'b0;
               if (w_slot_last) begin
                  r_state     <= FULL;
                  r_out_valid <= 1'b1;
                  r_final     <= 1'b1;
               end
            end
            FULL: if (out_ack) begin
               r_buf       <= '0;
               r_cnt       <= '0;
               r_out_valid <= 1'b0;
               r_msg_done  <= r_final;
               r_state     <= r_pad_pending ? PAD : ACCEPT;
            end
            default: r_state <= ACCEPT;
         endcase
      end
   end
   assign out_block = r_buf;
   assign out_valid = r_out_valid;
   assign msg_done  = r_msg_done;
endmodule

// File: tb/tb_sha3_pad_sequencer.sv
// tb_sha3_pad_sequencer: random and directed messages checked against a byte-level SHA3 padding model
`timescale 1ns/1ps
module tb_sha3_pad_sequencer;
   import sha3_pkg::*;
   localparam int RW = 17;
   localparam int BW = RW * 64;
   logic          clk = 1'b0;
   logic          reset;
   logic [63:0]   in;
   logic          in_valid;
   logic          in_ready;
   logic          is_last;
   logic [3:0]    byte_num;
`ifdef SHA3_PAD_SHAKE_EN
   logic          shake_mode;
`endif
   logic [BW-1:0] out_block;
   logic          out_valid;
   logic          out_ack;
   logic          msg_done;
   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            xfer_cyc;
   int            valid_cyc;
   logic [63:0]   msg [0:63];
   logic [BW-1:0] exp_blk [$];

   sha3_pad_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .in         (in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .is_last    (is_last),
      .byte_num   (byte_num),
`ifdef SHA3_PAD_SHAKE_EN
      .shake_mode (shake_mode),
`endif
      .out_block  (out_block),
      .out_valid  (out_valid),
      .out_ack    (out_ack),
      .msg_done   (msg_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", tag, act, exp);
      end
   endtask

   // standard SHA3 padding over the byte string: msg || ds || 0* with 0x80 ORed into the last rate byte
   task automatic build_exp(input int n, input int b, input logic [7:0] ds);
      logic [7:0]    q [$];
      logic [BW-1:0] v;
      int            nb;
      exp_blk.delete();
      for (int i = 0; i < n; i++) begin
         nb = (i == n - 1) ? ((b > 8) ? 8 : b) : 8;
         for (int j = 0; j < nb; j++) q.push_back(msg[i][63-8*j -: 8]);
      end
      q.push_back(ds);
      while (q.size() % 136 != 0) q.push_back(8'h00);
      q[q.size()-1] = q[q.size()-1] | PAD_END;
      for (int k = 0; k < q.size() / 136; k++) begin
         v = '0;
         for (int j = 0; j < 136; j++) v = {v[BW-9:0], q[k*136+j]};
         exp_blk.push_back(v);
      end
   endtask

   task automatic drive(input int n, input int b, input logic sm);
      int t;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in       = {$urandom, $urandom};
         is_last  = 1'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         in       = msg[i];
         is_last  = (i == n - 1);
         byte_num = is_last ? b[3:0] : 4'($urandom);
         in_valid = 1'b1;
`ifdef SHA3_PAD_SHAKE_EN
         shake_mode = is_last ? sm : 1'($urandom);
`endif
         t = 0;
         while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) begin
            check("in_ready_wait", BW'(in_ready), BW'(1));
            break;
         end
         if (is_last) xfer_cyc = cyc;
      end
      @(negedge clk);
      in_valid = 1'b0;
      is_last  = 1'b0;
   endtask

   task automatic monitor(input int hold);
      int            t;
      logic [BW-1:0] snap;
      for (int k = 0; k < exp_blk.size(); k++) begin
         t = 0;
         while (!out_valid && t < 400) begin
            out_ack = 1'($urandom);
            @(negedge clk);
            t++;
         end
         out_ack = 1'b0;
         check($sformatf("blk%0d_valid", k), BW'(out_valid), BW'(1));
         if (k == exp_blk.size() - 1) valid_cyc = cyc;
         check($sformatf("blk%0d_data", k), out_block, exp_blk[k]);
         snap = out_block;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", BW'(out_valid), BW'(1));
            check("hold_block", out_block, snap);
            check("hold_ready", BW'(in_ready), BW'(0));
         end
         out_ack = 1'b1;
         @(negedge clk);
         out_ack = 1'b0;
         check("ack_valid_drop", BW'(out_valid), BW'(0));
         check("msg_done", BW'(msg_done), BW'(k == exp_blk.size() - 1));
         if (k == exp_blk.size() - 1) begin
            check("ready_after_done", BW'(in_ready), BW'(1));
            @(negedge clk);
            check("msg_done_pulse", BW'(msg_done), BW'(0));
         end
      end
   endtask

   task automatic run_msg(input int n, input int b, input logic sm, input int hold);
      build_exp(n, b, sm ? PAD_DS_SHAKE : PAD_DS_SHA3);
      fork
         drive(n, b, sm);
         monitor(hold);
      join
      if (b < 8) check("latency", BW'(valid_cyc - xfer_cyc), BW'(17 - ((n - 1) % 17)));
   endtask

   initial begin
      logic seen;
      reset    = 1'b1;
      in       = '0;
      in_valid = 1'b0;
      is_last  = 1'b0;
      byte_num = '0;
      out_ack  = 1'b0;
`ifdef SHA3_PAD_SHAKE_EN
      shake_mode = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("ready_in_reset", BW'(in_ready), BW'(0));
      reset = 1'b0;
      #1;
      check("rst_valid", BW'(out_valid), BW'(0));
      check("rst_block", out_block, BW'(0));
      check("rst_done", BW'(msg_done), BW'(0));
      check("rst_ready", BW'(in_ready), BW'(1));
      @(negedge clk);
      // 17 full words, last one full: data block then an all-pad block
      for (int i = 0; i < 17; i++) msg[i] = {8{8'(i + 1)}};
      run_msg(17, 8, 1'b0, 0);
      // short single word
      msg[0] = 64'hAABBCCDDEEFF1122;
      run_msg(1, 3, 1'b0, 0);
      // last word with 7 bytes in the final slot
      for (int i = 0; i < 17; i++) msg[i] = {$urandom, $urandom};
      run_msg(17, 7, 1'b0, 0);
      // empty tail with a long ack stall
      msg[0] = {$urandom, $urandom};
      run_msg(1, 0, 1'b0, 10);
      // reset while the pad fill is in progress
      in       = {$urandom, $urandom};
      is_last  = 1'b1;
      byte_num = 4'd0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      is_last  = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("ready_in_mid_reset", BW'(in_ready), BW'(0));
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", BW'(out_valid), BW'(0));
      check("mid_rst_ready", BW'(in_ready), BW'(1));
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         seen = seen | out_valid | msg_done;
      end
      check("mid_rst_no_output", BW'(seen), BW'(0));
`ifdef SHA3_PAD_SHAKE_EN
      msg[0] = {$urandom, $urandom};
      run_msg(1, 2, 1'b1, 0);
      for (int i = 0; i < 17; i++) msg[i] = {$urandom, $urandom};
      run_msg(17, 7, 1'b1, 0);
`endif
      for (int r = 0; r < 12; r++) begin
         int   n;
         int   b;
         logic sm;
         n  = $urandom_range(1, 40);
         b  = $urandom_range(0, 15);
         sm = 1'b0;
`ifdef SHA3_PAD_SHAKE_EN
         sm = 1'($urandom);
`endif
         for (int i = 0; i < n; i++) msg[i] = {$urandom, $urandom};
         run_msg(n, b, sm, $urandom_range(0, 3));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
